// File: rtl/uart_tx_fifo_if.sv
// Host-side write port of the buffered UART transmitter: byte strobe in, FIFO status out.
interface uart_tx_fifo_if #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_FIFO = 4
);
  logic                  we;
  logic [WIDTH-1:0]      data_tx;
  logic                  full;
  logic [DEPTH_FIFO:0]   count;
  logic                  busy;

  modport master (output we, output data_tx, input full, input count, input busy);
  modport slave  (input we, input data_tx, output full, output count, output busy);
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes queue in a circular FIFO and are
// serialised LSB first on txd, back-to-back while the FIFO stays non-empty.
module uart_tx_fifo #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned SCLK_HZ    = 5000000,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_FIFO = 4
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_fifo_if.slave    bus,
  output logic             txd
);
  localparam int unsigned DIV     = CLK_HZ / SCLK_HZ;
  localparam int unsigned ENTRIES = 1 << DEPTH_FIFO;
  localparam int unsigned BAUD_W  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int unsigned BIT_W   = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [BAUD_W-1:0]     BAUD_RELOAD = BAUD_W'(DIV - 1);
  localparam logic [BAUD_W-1:0]     BAUD_ONE    = BAUD_W'(1);
  localparam logic [BIT_W-1:0]      BIT_LAST    = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0]      BIT_ONE     = BIT_W'(1);
  localparam logic [DEPTH_FIFO:0]   COUNT_FULL  = (DEPTH_FIFO + 1)'(ENTRIES);
  localparam logic [DEPTH_FIFO:0]   COUNT_ONE   = (DEPTH_FIFO + 1)'(1);
  localparam logic [DEPTH_FIFO-1:0] PTR_ONE     = DEPTH_FIFO'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [WIDTH-1:0]      shift_q, shift_d;
  logic                  txd_q, txd_d;
  logic                  busy_q, busy_d;
  logic [DEPTH_FIFO:0]   count_q, count_d;
  logic [DEPTH_FIFO-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_FIFO-1:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0]      mem_q [ENTRIES];

  logic full;
  logic push;
  logic pop;

  assign full      = (count_q == COUNT_FULL);
  assign push      = bus.we && !full;
  assign bus.full  = full;
  assign bus.count = count_q;
  assign bus.busy  = busy_q;
  assign txd       = txd_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.data_tx;
  end

  // txd_d is the line level for the state being entered, so txd stays a pure flop output.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          baud_d  = BAUD_RELOAD;
          state_d = START;
          txd_d   = 1'b0;
        end
      end
      START: begin
        if (baud_q == '0) begin
          state_d = DATA;
          bit_d   = '0;
          baud_d  = BAUD_RELOAD;
          txd_d   = shift_q[0];
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
      DATA: begin
        if (baud_q == '0) begin
          shift_d = shift_q >> 1;
          baud_d  = BAUD_RELOAD;
          if (bit_q == BIT_LAST) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d = bit_q + BIT_ONE;
            txd_d = shift_d[0];
          end
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
      STOP: begin
        if (baud_q == '0) begin
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            baud_d  = BAUD_RELOAD;
            state_d = START;
            txd_d   = 1'b0;
          end else begin
            state_d = IDLE;
            txd_d   = 1'b1;
          end
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + COUNT_ONE;
      2'b01:   count_d = count_q - COUNT_ONE;
      default: count_d = count_q;
    endcase
    busy_d = (state_d != IDLE) || (count_q != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: expected bytes are queued at write time and a
// line monitor decodes txd cycle by cycle against the queue head.
module tb_uart_tx_fifo;
  localparam int unsigned CLK_HZ     = 50000000;
  localparam int unsigned SCLK_HZ    = 5000000;
  localparam int unsigned WIDTH      = 8;
  localparam int unsigned DEPTH_FIFO = 4;
  localparam int          DIV        = CLK_HZ / SCLK_HZ;
  localparam int          FRAME      = (WIDTH + 2) * DIV;

  logic clk = 1'b0;
  logic rst_n;
  logic txd;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] exp_q[$];
  int         starts_q[$];

  uart_tx_fifo_if #(.WIDTH(WIDTH), .DEPTH_FIFO(DEPTH_FIFO)) bus ();

  uart_tx_fifo #(
    .CLK_HZ(CLK_HZ),
    .SCLK_HZ(SCLK_HZ),
    .WIDTH(WIDTH),
    .DEPTH_FIFO(DEPTH_FIFO)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .bus(bus.slave),
    .txd(txd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Line monitor: offset 0 is the first cycle the start bit is seen low.
  initial begin : monitor
    logic       rx_active;
    logic       rx_bogus;
    int         rx_off;
    logic [7:0] exp_byte;
    logic       exp_bit;
    int         k;
    rx_active = 1'b0;
    rx_bogus  = 1'b0;
    rx_off    = 0;
    exp_byte  = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        rx_active = 1'b0;
      end else if (!rx_active) begin
        if (txd === 1'b0) begin
          rx_active = 1'b1;
          rx_off    = 0;
          starts_q.push_back(cyc);
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            rx_bogus = 1'b1;
            $display("FAIL unexpected_frame: got start bit expected idle line at cycle %0d", cyc);
          end else begin
            rx_bogus = 1'b0;
            exp_byte = exp_q.pop_front();
          end
        end
      end else begin
        rx_off++;
        k = rx_off / DIV;
        if (k == 0) exp_bit = 1'b0;
        else if (k <= WIDTH) exp_bit = exp_byte[k-1];
        else exp_bit = 1'b1;
        if (!rx_bogus) chk($sformatf("txd_frame_%02h_off%0d", exp_byte, rx_off), {31'd0, txd}, {31'd0, exp_bit});
        if (rx_off == FRAME - 1) rx_active = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #(60000 * 10);
    $display("FAIL watchdog: got no finish expected finish within 60000 cycles");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(bus.busy === 1'b0 && bus.count === '0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("wait_idle_timeout", 32'd1, 32'd0);
    repeat (5) @(negedge clk);
  endtask

  task automatic put(input logic [7:0] b, input bit accept);
    bus.we      = 1'b1;
    bus.data_tx = b;
    if (accept) exp_q.push_back(b);
  endtask

  initial begin : stim
    int bcnt;
    int k;
    int n;
    rst_n       = 1'b1;
    bus.we      = 1'b0;
    bus.data_tx = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_txd",   {31'd0, txd},       32'd1);
    chk("rst_busy",  {31'd0, bus.busy},  32'd0);
    chk("rst_full",  {31'd0, bus.full},  32'd0);
    chk("rst_count", 32'(bus.count),     32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_txd",  {31'd0, txd},      32'd1);
    chk("idle_busy", {31'd0, bus.busy}, 32'd0);

    // Single byte 0x55: pop one edge after the write, busy for exactly one frame.
    starts_q.delete();
    put(8'h55, 1'b1);
    @(negedge clk);
    bus.we = 1'b0;
    chk("single_count_after_write", 32'(bus.count), 32'd1);
    chk("single_busy_after_write",  {31'd0, bus.busy}, 32'd0);
    chk("single_txd_after_write",   {31'd0, txd}, 32'd1);
    @(negedge clk);
    chk("single_count_after_pop", 32'(bus.count), 32'd0);
    chk("single_busy_after_pop",  {31'd0, bus.busy}, 32'd1);
    chk("single_txd_start",       {31'd0, txd}, 32'd0);
    bcnt = 1;
    repeat (199) begin
      @(negedge clk);
      if (bus.busy === 1'b1) bcnt++;
    end
    chk("single_busy_cycles", 32'(bcnt), 32'd100);
    chk("single_frames", 32'(starts_q.size()), 32'd1);

    // 'H' then 'i' on consecutive cycles: start bits exactly one frame apart.
    starts_q.delete();
    put(8'h48, 1'b1);
    @(negedge clk);
    put(8'h69, 1'b1);
    @(negedge clk);
    bus.we = 1'b0;
    wait_idle();
    chk("hi_frames", 32'(starts_q.size()), 32'd2);
    if (starts_q.size() == 2) chk("hi_start_spacing", 32'(starts_q[1] - starts_q[0]), 32'(FRAME));

    // Overflow: 0x00 pops at once, 0x01..0x10 fill 16 entries, 0x11 dropped.
    for (int i = 0; i < 18; i++) begin
      put(8'(i), i != 17);
      @(negedge clk);
      if (i == 15) chk("ovf_full_at_15", {31'd0, bus.full}, 32'd0);
      if (i == 16) begin
        chk("ovf_count_16", 32'(bus.count), 32'd16);
        chk("ovf_full_16",  {31'd0, bus.full}, 32'd1);
      end
      if (i == 17) begin
        chk("ovf_count_drop", 32'(bus.count), 32'd16);
        chk("ovf_full_drop",  {31'd0, bus.full}, 32'd1);
      end
    end
    bus.we = 1'b0;
    repeat (83) @(negedge clk);
    chk("ovf_full_before_pop1", {31'd0, bus.full}, 32'd1);
    @(negedge clk);
    chk("ovf_full_after_pop1",  {31'd0, bus.full}, 32'd0);
    chk("ovf_count_after_pop1", 32'(bus.count), 32'd15);
    wait_idle();

    // Write lands on the edge where STOP ends while one byte is queued.
    starts_q.delete();
    put(8'hC3, 1'b1);
    @(negedge clk);
    bus.we = 1'b0;
    @(negedge clk);
    put(8'h3C, 1'b1);
    @(negedge clk);
    bus.we = 1'b0;
    chk("simul_count_before", 32'(bus.count), 32'd1);
    repeat (98) @(negedge clk);
    chk("simul_count_stop_end", 32'(bus.count), 32'd1);
    put(8'h81, 1'b1);
    @(negedge clk);
    bus.we = 1'b0;
    chk("simul_count_after", 32'(bus.count), 32'd1);
    wait_idle();
    chk("simul_frames", 32'(starts_q.size()), 32'd3);
    if (starts_q.size() == 3) begin
      chk("simul_spacing_1", 32'(starts_q[1] - starts_q[0]), 32'(FRAME));
      chk("simul_spacing_2", 32'(starts_q[2] - starts_q[1]), 32'(FRAME));
    end

    // Reset during data bit 3 of 0xA5 with three bytes behind it.
    starts_q.delete();
    put(8'hA5, 1'b1);
    @(negedge clk);
    put(8'h11, 1'b1);
    @(negedge clk);
    put(8'h22, 1'b1);
    @(negedge clk);
    put(8'h33, 1'b1);
    @(negedge clk);
    bus.we = 1'b0;
    repeat (40) @(negedge clk);
    chk("mid_count_before", 32'(bus.count), 32'd3);
    chk("mid_txd_bit3",     {31'd0, txd}, 32'd0);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_txd",   {31'd0, txd},      32'd1);
    chk("mid_rst_busy",  {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_count", 32'(bus.count),    32'd0);
    chk("mid_rst_full",  {31'd0, bus.full}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (300) begin
      @(negedge clk);
      if (txd !== 1'b1 || bus.busy !== 1'b0) n++;
    end
    chk("mid_quiet_cycles_bad", 32'(n), 32'd0);
    chk("mid_frames", 32'(starts_q.size()), 32'd1);

    // Pointer wrap: 40 bytes streamed with occupancy held at or below 15.
    starts_q.delete();
    k = 0;
    n = 0;
    while (k < 40 && n < 20000) begin
      if (bus.count <= 14) begin
        put(8'(8'h30 + k), 1'b1);
        k++;
      end else begin
        bus.we = 1'b0;
      end
      @(negedge clk);
      n++;
      chk("wrap_full", {31'd0, bus.full}, 32'd0);
    end
    bus.we = 1'b0;
    chk("wrap_all_written", 32'(k), 32'd40);
    wait_idle();
    chk("wrap_frames", 32'(starts_q.size()), 32'd40);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("final_txd", {31'd0, txd}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
